ka59_seq: RTL and testbench

Sequential 59x59-bit carry-less (GF(2) polynomial) multiplier controller. It time-multiplexes a single combinational `KA30` core (30x30 carry-less multiply, 59-bit result) over three cycles to compute the Karatsuba partial products T0, T1 and T2. It then recombines them into the 117-bit product. The block replaces a fully unrolled 59-bit Karatsuba tree where area matters more than throughput, and sits between an operand producer and a result consumer using valid/ready handshakes.

---
 rtl/ka59_seq.sv | 123 ++++++++++++
 tb/tb_ka59_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ka59_seq.sv
// ka59_seq: sequential 59x59 carry-less multiplier. One shared 30x30 carry-less
// core is reused over three cycles to form the Karatsuba terms T0 (low halves),
// T1 (high halves) and T2 (cross sums), which are then XOR-recombined into a
// 117-bit product. Valid/ready handshakes on both the operand and result sides.
module ka59_seq #(
  parameter int unsigned N = 59,
  parameter int unsigned C = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-2:0]   O,
  output logic             busy
);

  typedef enum logic [2:0] {StIdle, StLo, StHi, StMid, StDone} state_e;

  state_e        state_q, state_d;
  logic [58:0]   ra_q, ra_d, rb_q, rb_d;
  logic [58:0]   t0_q, t0_d;
  logic [56:0]   t1_q, t1_d;
  logic [58:0]   t2_q, t2_d;
  logic [116:0]  o_q, o_d;

  logic [29:0]   core_a, core_b;
  logic [58:0]   core_p;
  logic [58:0]   mid;
  logic          xfer;

  // Operand mux for the shared core, selected by the current phase.
  always_comb begin
    core_a = ra_q[29:0];
    core_b = rb_q[29:0];
    unique case (state_q)
      StHi: begin
        core_a = {1'b0, ra_q[58:30]};
        core_b = {1'b0, rb_q[58:30]};
      end
      StMid: begin
        core_a = {1'b0, ra_q[58:30]} ^ ra_q[29:0];
        core_b = {1'b0, rb_q[58:30]} ^ rb_q[29:0];
      end
      default: ;
    endcase
  end

  // 30x30 carry-less core: XOR of shifted partial products.
  always_comb begin
    core_p = '0;
    for (int i = 0; i < 30; i++) begin
      if (core_b[i]) core_p = core_p ^ ({29'b0, core_a} << i);
    end
  end

  // Handshake decode and FSM next state.
  always_comb begin
    in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    xfer      = in_valid && in_ready;
    state_d   = state_q;
    unique case (state_q)
      StIdle:  if (xfer) state_d = StLo;
      StLo:    state_d = StHi;
      StHi:    state_d = StMid;
      StMid:   state_d = StDone;
      StDone:  if (out_ready) state_d = xfer ? StLo : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next state: operand capture, per-phase term capture, recombination.
  always_comb begin
    ra_d = ra_q;
    rb_d = rb_q;
    t0_d = t0_q;
    t1_d = t1_q;
    t2_d = t2_q;
    o_d  = o_q;
    // Middle Karatsuba term; T2 comes straight from the core in the StMid cycle.
    mid  = t0_q ^ {2'b0, t1_q} ^ core_p;
    if (xfer) begin
      ra_d = A;
      rb_d = B;
    end
    if (state_q == StLo) t0_d = core_p;
    // High-half product is at most degree 56, so the top two core bits are dropped.
    if (state_q == StHi) t1_d = core_p[56:0];
    if (state_q == StMid) begin
      t2_d = core_p;
      o_d  = {t1_q, 60'b0} ^ {28'b0, mid, 30'b0} ^ {58'b0, t0_q};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      o_q     <= o_d;
    end
  end

  assign O = o_q;

endmodule

// File: tb/tb_ka59_seq.sv
// Randomised self-checking bench for ka59_seq against a full-width carry-less
// reference product.
module tb_ka59_seq;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [58:0]   A;
  logic [58:0]   B;
  logic          out_valid;
  logic          out_ready;
  logic [116:0]  O;
  logic          busy;

  int n_checks;
  int n_errors;

  ka59_seq #(.N(59), .C(30)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .O         (O),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: schoolbook polynomial product over GF(2) on the full operands.
  function automatic logic [116:0] clmul(input logic [58:0] a, input logic [58:0] b);
    logic [116:0] r;
    r = '0;
    for (int i = 0; i < 59; i++) begin
      if (b[i]) r = r ^ ({58'b0, a} << i);
    end
    return r;
  endfunction

  function automatic logic [58:0] rand59();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[58:0];
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction with out_ready high: checks latency, in_ready/busy and the product.
  task automatic run_op(input logic [58:0] a, input logic [58:0] b, input logic [116:0] exp);
    int lat;
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    #1 check_eq("op_in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; A = rand59(); B = rand59();
    lat = 1;
    while (!out_valid && lat < 12) begin
      #1 check_eq("op_in_ready_busy", in_ready, 0);
      check_eq("op_busy", busy, 1);
      @(negedge clk);
      lat++;
    end
    check_eq("op_latency", lat, 4);
    check_eq("op_product", O, exp);
    @(negedge clk);
    #1 check_eq("op_accepted", out_valid, 0);
  endtask

  // Streams npairs operand pairs through the block and scoreboards the results.
  task automatic stream(input int npairs, input bit rnd);
    logic [116:0] expq[$];
    logic [58:0]  ca, cb;
    int sent, cyc, last_out;
    sent = 0; cyc = 0; last_out = -1;
    ca = rand59(); cb = rand59();
    while ((sent < npairs || expq.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (sent >= npairs) in_valid = 1'b0;
      else if (!in_valid) in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      A = ca; B = cb;
      #1;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check_eq("stream_spurious", out_valid, 0);
        else check_eq("stream_product", O, expq.pop_front());
        if (!rnd && last_out >= 0) check_eq("b2b_gap", cyc - last_out, 4);
        last_out = cyc;
      end
      if (in_valid && in_ready) begin
        expq.push_back(clmul(ca, cb));
        sent++;
        ca = rand59(); cb = rand59();
      end
    end
    in_valid = 1'b0;
    check_eq("stream_complete", (sent == npairs) && (expq.size() == 0), 1);
  endtask

  initial begin
    logic [116:0] e;
    logic [58:0]  a, b;
    int w;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_O", O, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(59'd1, 59'd1, 117'd1);
    run_op(59'd3, 59'd3, 117'd5);
    e = 117'd1 << 116;
    run_op(59'd1 << 58, 59'd1 << 58, e);
    run_op(59'h7FFFFFFFFFFFFFF, 59'd1, {58'b0, 59'h7FFFFFFFFFFFFFF});
    e = 117'd1 << 59;
    run_op(59'd1 << 29, 59'd1 << 30, e);

    // Backpressure: result must hold and in_ready stay low while out_ready is low.
    a = rand59(); b = rand59();
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 12) begin
      @(negedge clk);
      w++;
    end
    check_eq("bp_out_valid", out_valid, 1);
    check_eq("bp_product", O, clmul(a, b));
    repeat (5) begin
      @(negedge clk);
      A = rand59(); B = rand59(); in_valid = $urandom_range(0, 1) != 0;
      #1;
      check_eq("bp_hold_O", O, clmul(a, b));
      check_eq("bp_hold_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1 check_eq("bp_release_ready", in_ready, 1);
    @(negedge clk);
    #1 check_eq("bp_single_accept", out_valid, 0);
    check_eq("bp_idle", busy, 0);

    // Back-to-back, then a long randomised run.
    stream(3, 1'b0);
    stream(1000, 1'b1);

    // Reset asserted while in the high-half phase.
    @(negedge clk);
    A = rand59() | 59'd1; B = rand59() | 59'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 check_eq("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_O", O, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(59'd5, 59'd5, 117'd17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
